// File: rtl/dmem_lsu_pkg.sv
// Shared constants and types for the data-memory load/store unit.
// funct3 codes, FSM state encoding and the illegal-funct3 helper.
package dmem_lsu_pkg;

  localparam int WORD_LEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_RDATA,
    S_WRITE,
    S_ERR
  } lsu_state_t;

  // funct3 values that have no meaning for the given access direction
  function automatic logic f3_illegal(
    input logic       is_store,
    input logic [2:0] f3
  );
    if (is_store)
      return f3[2] | (f3 == 3'b011);
    return (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte/halfword lane steering for the load/store unit.
// Extracts and extends load lanes, merges sub-word stores, flags misalignment.
module dmem_lane_align
  import dmem_lsu_pkg::*;
(
  input  logic [2:0]          funct3,
  input  logic [1:0]          addr,
  input  logic [WORD_LEN-1:0] rdata,
  input  logic [WORD_LEN-1:0] wdata,
  output logic [WORD_LEN-1:0] load_ext,
  output logic [WORD_LEN-1:0] store_merge,
  output logic                misalign
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // lane select, sign/zero extension, sub-word merge and alignment check
  always_comb begin
    lane_b      = rdata[{addr, 3'b000} +: 8];
    lane_h      = rdata[{addr[1], 4'b0000} +: 16];
    load_ext    = '0;
    store_merge = rdata;
    misalign    = 1'b0;

    case (funct3)
      F3_LB:   load_ext = {{24{lane_b[7]}}, lane_b};
      F3_LH:   load_ext = {{16{lane_h[15]}}, lane_h};
      F3_LW:   load_ext = rdata;
      F3_LBU:  load_ext = {24'h0, lane_b};
      F3_LHU:  load_ext = {16'h0, lane_h};
      default: load_ext = '0;
    endcase

    case (funct3[1:0])
      2'b00:   store_merge[{addr, 3'b000} +: 8] = wdata[7:0];
      2'b01:   store_merge[{addr[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_merge = wdata;
    endcase

    case (funct3[1:0])
      2'b01:   misalign = addr[0];
      2'b10:   misalign = (addr != 2'b00);
      default: misalign = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// RV32I load/store unit in front of a word-wide, 1-cycle-read memory port.
// Sub-word stores are done as read-modify-write of the containing word.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter bit STORE_RESP = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [2:0]          req_funct3,
  input  logic [WORD_LEN-1:0] req_addr,
  input  logic [WORD_LEN-1:0] req_wdata,
  output logic                resp_valid,
  output logic [WORD_LEN-1:0] resp_rdata,
  output logic                resp_err,
  output logic [WORD_LEN-1:0] addr_d,
  output logic                wen,
  output logic [WORD_LEN-1:0] wdata,
  input  logic [WORD_LEN-1:0] rdata
);

  lsu_state_t          state;
  logic [WORD_LEN-1:0] addr_q;
  logic [WORD_LEN-1:0] wdata_q;
  logic [WORD_LEN-1:0] merge_q;
  logic [2:0]          funct3_q;
  logic                wen_q;

  logic                idle;
  logic                accept;
  logic                req_err;
  logic [2:0]          lane_f3;
  logic [1:0]          lane_addr;
  logic [WORD_LEN-1:0] addr_w;
  logic [WORD_LEN-1:0] load_ext;
  logic [WORD_LEN-1:0] store_merge;
  logic                misalign;

  assign idle      = (state == S_IDLE);
  assign req_ready = idle & ~rst;
  assign accept    = req_valid & req_ready;

  // alignment is judged on the live request; extraction on the latched one
  assign lane_f3   = idle ? req_funct3 : funct3_q;
  assign lane_addr = idle ? req_addr[1:0] : addr_q[1:0];
  assign addr_w    = {addr_q[WORD_LEN-1:2], 2'b00};
  assign req_err   = misalign | f3_illegal(req_wen, req_funct3);

  dmem_lane_align u_align (
    .funct3      (lane_f3),
    .addr        (lane_addr),
    .rdata       (rdata),
    .wdata       (wdata_q),
    .load_ext    (load_ext),
    .store_merge (store_merge),
    .misalign    (misalign)
  );

  // memory port driven only in READ/WRITE; reset blocks a pending write
  always_comb begin
    addr_d = '0;
    wen    = 1'b0;
    wdata  = '0;
    case (state)
      S_READ: addr_d = addr_w;
      S_WRITE: begin
        addr_d = addr_w;
        wen    = ~rst;
        wdata  = (funct3_q[1:0] == 2'b10) ? wdata_q : merge_q;
      end
      default: ;
    endcase
  end

  // request FSM with registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      funct3_q   <= '0;
      wen_q      <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            wen_q    <= req_wen;
            if (req_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= S_ERR;
            end else if (req_wen && req_funct3 == F3_SW) begin
              state <= S_WRITE;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_READ: state <= S_RDATA;
        S_RDATA: begin
          if (wen_q) begin
            merge_q <= store_merge;
            state   <= S_WRITE;
          end else begin
            resp_valid <= 1'b1;
            resp_rdata <= load_ext;
            resp_err   <= 1'b0;
            state      <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (STORE_RESP) begin
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
          state <= S_IDLE;
        end
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a 1-cycle registered word memory model.
// A second instance with STORE_RESP=0 shadows the same request stream.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_init;
  logic        req_valid;
  logic        req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        req_ready, resp_valid, resp_err, wen;
  logic [31:0] resp_rdata, addr_d, wdata, rdata;
  logic        ready0, rv0, er0, wen0;
  logic [31:0] rd0, ad0, wd0, rdata0;

  logic [31:0] mem  [0:255];
  logic [31:0] mem0 [0:255];

  int nvec = 0;
  int nbad = 0;

  typedef struct {
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
    int          lat;
    int          wcyc;
    logic [31:0] wa;
    logic [31:0] wv;
  } vec_t;

  vec_t vt [17];
  vec_t vr;

  always #5 clk = ~clk;

  dmem_lsu #(.STORE_RESP(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .addr_d(addr_d),
    .wen(wen), .wdata(wdata), .rdata(rdata)
  );

  dmem_lsu #(.STORE_RESP(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(ready0),
    .req_wen(req_wen), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_rdata(rd0),
    .resp_err(er0), .addr_d(ad0),
    .wen(wen0), .wdata(wd0), .rdata(rdata0)
  );

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem[i]  <= 32'h0;
        mem0[i] <= 32'h0;
      end
      mem[64]  <= 32'h8899AABB;
      mem0[64] <= 32'h8899AABB;
    end else begin
      if (wen)  mem[addr_d[9:2]] <= wdata;
      if (wen0) mem0[ad0[9:2]]   <= wd0;
    end
    rdata  <= mem[addr_d[9:2]];
    rdata0 <= mem0[ad0[9:2]];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_wen    = v.wen;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wd;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int rc, wc, wn, rn, r0, w;
    logic [31:0] rd, wa, wv;
    logic er;
    string tag;
    tag = $sformatf("v%0d", id);
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " ready"}, {31'h0, req_ready}, 32'h1);
    drive(v);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rc = 0; wc = 0; wn = 0; rn = 0; r0 = 0;
    rd = 0; wa = 0; wv = 0; er = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (wen) begin
        wn++; wc = k; wa = addr_d; wv = wdata;
      end
      if (resp_valid) begin
        rn++; rc = k; rd = resp_rdata; er = resp_err;
      end
      if (rv0) r0++;
    end
    chk({tag, " resp_cnt"}, rn, 1);
    chk({tag, " resp_cyc"}, rc, v.lat);
    chk({tag, " rdata"}, rd, v.rd);
    chk({tag, " err"}, {31'h0, er}, {31'h0, v.err});
    chk({tag, " wen_cnt"}, wn, (v.wcyc != 0) ? 1 : 0);
    chk({tag, " nsr_resp"}, r0, (v.wen && !v.err) ? 0 : 1);
    if (v.wcyc != 0) begin
      chk({tag, " wen_cyc"}, wc, v.wcyc);
      chk({tag, " waddr"}, wa, v.wa);
      chk({tag, " wdata"}, wv, v.wv);
    end
  endtask

  // back-to-back stream with req_valid held high
  vec_t bb [4];
  int   rdy_exp [12];
  logic [31:0] bb_rd [4];
  logic        bb_er [4];
  int          bb_rc [4];

  initial begin
    int idx, nr, rn;
    logic acc;
    logic [31:0] got_rd [8];
    logic        got_er [8];
    int          got_rc [8];

    vt[0]  = '{1'b0, 3'b000, 32'h101, 32'h0, 1'b0, 32'hFFFFFFAA, 3, 0, 32'h0, 32'h0};
    vt[1]  = '{1'b0, 3'b100, 32'h103, 32'h0, 1'b0, 32'h00000088, 3, 0, 32'h0, 32'h0};
    vt[2]  = '{1'b0, 3'b001, 32'h102, 32'h0, 1'b0, 32'hFFFF8899, 3, 0, 32'h0, 32'h0};
    vt[3]  = '{1'b0, 3'b101, 32'h100, 32'h0, 1'b0, 32'h0000AABB, 3, 0, 32'h0, 32'h0};
    vt[4]  = '{1'b1, 3'b000, 32'h102, 32'h12345655, 1'b0, 32'h0, 4, 3, 32'h100, 32'h8855AABB};
    vt[5]  = '{1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'h8855AABB, 3, 0, 32'h0, 32'h0};
    vt[6]  = '{1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1, 32'h104, 32'hDEADBEEF};
    vt[7]  = '{1'b0, 3'b010, 32'h104, 32'h0, 1'b0, 32'hDEADBEEF, 3, 0, 32'h0, 32'h0};
    vt[8]  = '{1'b0, 3'b010, 32'h106, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0, 32'h0};
    vt[9]  = '{1'b1, 3'b001, 32'h103, 32'hFFFF, 1'b1, 32'h0, 1, 0, 32'h0, 32'h0};
    vt[10] = '{1'b0, 3'b011, 32'h100, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0, 32'h0};
    vt[11] = '{1'b1, 3'b100, 32'h100, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0, 32'h0};
    vt[12] = '{1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'h8855AABB, 3, 0, 32'h0, 32'h0};
    vt[13] = '{1'b1, 3'b001, 32'h106, 32'h0000CAFE, 1'b0, 32'h0, 4, 3, 32'h104, 32'hCAFEBEEF};
    vt[14] = '{1'b0, 3'b001, 32'h106, 32'h0, 1'b0, 32'hFFFFCAFE, 3, 0, 32'h0, 32'h0};
    vt[15] = '{1'b0, 3'b000, 32'h104, 32'h0, 1'b0, 32'hFFFFFFEF, 3, 0, 32'h0, 32'h0};
    vt[16] = '{1'b0, 3'b100, 32'h105, 32'h0, 1'b0, 32'h000000BE, 3, 0, 32'h0, 32'h0};

    bb[0] = '{1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'h8855AABB, 0, 0, 32'h0, 32'h0};
    bb[1] = '{1'b1, 3'b010, 32'h108, 32'h0BADF00D, 1'b0, 32'h0, 0, 0, 32'h0, 32'h0};
    bb[2] = '{1'b0, 3'b011, 32'h100, 32'h0, 1'b1, 32'h0, 0, 0, 32'h0, 32'h0};
    bb[3] = '{1'b0, 3'b010, 32'h108, 32'h0, 1'b0, 32'h0BADF00D, 0, 0, 32'h0, 32'h0};
    rdy_exp = '{1, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 1};
    bb_rc   = '{3, 5, 6, 10};

    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst wen", {31'h0, wen}, 32'h0);
    chk("rst addr_d", addr_d, 32'h0);
    chk("rst wdata", wdata, 32'h0);
    chk("rst req_ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    chk("post-rst ready", {31'h0, req_ready}, 32'h1);

    // directed vector table
    for (int i = 0; i < 17; i++)
      run_vec(vt[i], i);

    // back-to-back stream
    @(posedge clk);
    #1;
    idx = 0; nr = 0;
    drive(bb[0]);
    req_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("bb ready c%0d", c), {31'h0, req_ready},
          rdy_exp[c]);
      if (resp_valid && nr < 8) begin
        got_rd[nr] = resp_rdata;
        got_er[nr] = resp_err;
        got_rc[nr] = c;
        nr++;
      end
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 4) drive(bb[idx]);
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("bb resp_cnt", nr, 4);
    for (int i = 0; i < 4; i++) begin
      bb_rd[i] = bb[i].rd;
      bb_er[i] = bb[i].err;
      if (i < nr) begin
        chk($sformatf("bb%0d rdata", i), got_rd[i], bb_rd[i]);
        chk($sformatf("bb%0d err", i), {31'h0, got_er[i]},
            {31'h0, bb_er[i]});
        chk($sformatf("bb%0d cyc", i), got_rc[i], bb_rc[i]);
      end
    end

    // reset during the write cycle of SB 0x100
    @(negedge clk);
    vr = '{1'b1, 3'b000, 32'h100, 32'h77, 1'b0, 32'h0, 0, 0, 32'h0, 32'h0};
    drive(vr);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rstw wen", {31'h0, wen}, 32'h0);
    chk("rstw resp", {31'h0, resp_valid}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    rn = 0;
    @(negedge clk);
    chk("rstw ready", {31'h0, req_ready}, 32'h1);
    if (resp_valid) rn++;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) rn++;
    end
    chk("rstw no resp", rn, 0);
    vr = '{1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'h8855AABB, 3, 0, 32'h0, 32'h0};
    run_vec(vr, 99);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
